aes_key_schedule_iter: RTL
==========================

// Module: aes_key_schedule_iter
// PURPOSE
//  Iterative FIPS-197 key expansion for AES-128/192/256, runtime-selectable.
//  Generates one 32-bit schedule word per clock into internal word storage.
//  Round keys are then read back by round index.
//  Feeds the AES round datapath in place of the flat, combinational round-key bus.
// PARAMETERS
//  MAX_KEY_BITS  256  largest key supported (128|192|256); sizes storage to 4*(Nr_max+1) words
//  RIDX_W        4    width of the round-index read port
// PORTS
//  clk         in   1         system clock, rising edge
//  rst         in   1         asynchronous, active-high reset
//  start       in   1         request expansion; sampled only in IDLE
//  mode        in   2         0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//  key         in   256       cipher key, left-aligned: w0 = key[255:224]; unused LSBs ignored
//  busy        out  1         expansion in progress
//  done        out  1         one-cycle pulse when the last word is written
//  err         out  1         one-cycle pulse: start with illegal/unsupported mode
//  keys_valid  out  1         stored schedule complete and consistent
//  num_rounds  out  4         Nr of the stored schedule (10/12/14); 0 after reset
//  rd_round    in   RIDX_W    round index to read
//  rd_key      out  128       round key rd_round, registered; 1-cycle read latency
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All outputs are 0. FSM=IDLE. keys_valid=0.
//   - Stored words are not cleared.
//  Nk/Nr/total words: mode0 4/10/44, mode1 6/12/52, mode2 8/14/60.
//  FSM IDLE -> LOAD -> EXPAND -> IDLE.
//   - IDLE: on start with legal mode, latch key and mode; busy<=1 and keys_valid<=0 next cycle.
//     Illegal mode (3, or Nk*32 > MAX_KEY_BITS): err pulses next cycle, stay IDLE, keys_valid unchanged.
//   - LOAD (1 cycle): write w[0..Nk-1] from the latched key. i<=Nk.
//   - EXPAND (1 word/cycle):
//     - temp=w[i-1].
//     - If i%Nk==0: temp=SubWord(RotWord(temp))^{Rcon[i/Nk],24'h0}.
//     - Else if Nk==8 and i%8==4: temp=SubWord(temp).
//     - w[i]=w[i-Nk]^temp.
//     - After writing w[total-1]: IDLE, busy<=0, done=1 for 1 cycle, keys_valid<=1, num_rounds<=Nr.
//  Latency: start edge T -> done high in cycle T+(total-Nk)+2 = 42/48/54 cycles (mode0/1/2).
//  start, mode and key changes while busy are ignored; the latched copies are used.
//  Read port:
//   - rd_key <= {w[4r],w[4r+1],w[4r+2],w[4r+3]} with r=rd_round, every cycle.
//   - rd_round>num_rounds, or keys_valid=0: rd_key <= 0.
//  Reset mid-EXPAND: abort to IDLE immediately, keys_valid=0, no done pulse.
//  Back-to-back: start in the cycle after done is accepted (FSM is already IDLE).
//  Rcon: 01,02,04,08,10,20,40,80,1b,36. Max index used is 10 (AES-128).
// STRUCTURE
//  Package aes_pkg:
//   - mode encodings (AES128/192/256)
//   - NK/NR/NWORDS lookup functions
//   - RCON table
//   - aes_word_t (32-bit) typedef
//  Sub-module aes_sbox:
//   - combinational 8-bit S-box, 4 instances for SubWord
//   - shared with the cipher SubBytes path
//  Word storage is a 60x32 register array; synthesis may infer distributed RAM.
// TESTING
//  1. AES-128 key 2b7e151628aed2a6abf7158809cf4f3c
//     -> done at T+42; rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; num_rounds=10.
//  2. AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (left-aligned)
//     -> done at T+48; round 12 = e98ba06f448c773c8ecc720401002202.
//  3. AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
//     -> done at T+54; round 14 = fe4890d1e6188d0b046df344706c631e; round 0 = key[255:128].
//  4. start with mode=3
//     -> err=1 one cycle, busy stays 0, prior keys_valid/rd_key unchanged.
//     Then rd_round=11 after an AES-128 run -> rd_key=0.
//  5. Assert rst at cycle T+20 of an AES-256 run
//     -> busy=0, keys_valid=0, no done.
//     Restart with AES-128 vector -> test 1 result.
//  6. Toggle start/key every cycle while busy
//     -> result identical to test 1, exactly one done pulse.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encodings, per-mode schedule geometry and the Rcon table.
package aes_pkg;

    typedef logic [31:0] aes_word_t;

    localparam logic [1:0] MODE_AES128 = 2'd0;
    localparam logic [1:0] MODE_AES192 = 2'd1;
    localparam logic [1:0] MODE_AES256 = 2'd2;

    function automatic logic [5:0] aes_nk(input logic [1:0] m);
        case (m)
            MODE_AES192: return 6'd6;
            MODE_AES256: return 6'd8;
            default:     return 6'd4;
        endcase
    endfunction

    function automatic logic [3:0] aes_nr(input logic [1:0] m);
        case (m)
            MODE_AES192: return 4'd12;
            MODE_AES256: return 4'd14;
            default:     return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] aes_nwords(input logic [1:0] m);
        case (m)
            MODE_AES192: return 6'd52;
            MODE_AES256: return 6'd60;
            default:     return 6'd44;
        endcase
    endfunction

    function automatic logic aes_mode_legal(input logic [1:0] m, input int max_bits);
        return (m != 2'd3) && (int'(aes_nk(m)) * 32 <= max_bits);
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (as x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^(2+4+...+128); zero maps to zero as required.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock, with a
// registered round-key read port.
module aes_key_schedule_iter
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256,
    parameter int RIDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [255:0]      key,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              keys_valid,
    output logic [3:0]        num_rounds,
    input  logic [RIDX_W-1:0] rd_round,
    output logic [127:0]      rd_key
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | copy latched key into w[0..Nk-1]
    // EXPAND | derive one word w[i] per cycle
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_EXPAND = 2'd2;

    localparam int NWORDS_MAX = (MAX_KEY_BITS <= 128) ? 44 : (MAX_KEY_BITS <= 192) ? 52 : 60;

    logic [1:0]   state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [1:0]   mode_q, mode_d;
    logic [5:0]   idx_q, idx_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [3:0]   rc_q, rc_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         kv_q, kv_d;
    logic [3:0]   nr_q, nr_d;
    logic [127:0] rd_key_q, rd_key_d;
    logic         load_en, wr_en;

    aes_word_t w_q [NWORDS_MAX];
    aes_word_t w_prev, w_back, sub_in, sub_out, temp, w_new;
    logic [5:0] nk, nwords, rd_base;

    assign nk     = aes_nk(mode_q);
    assign nwords = aes_nwords(mode_q);

    // i%Nk is tracked by cnt_q and i/Nk by rc_q, avoiding any divider.
    always_comb begin
        w_prev = w_q[idx_q - 6'd1];
        w_back = w_q[idx_q - nk];
        sub_in = (cnt_q == 6'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        if (cnt_q == 6'd0)
            temp = sub_out ^ {aes_rcon(rc_q), 24'h0};
        else if (nk == 6'd8 && cnt_q == 6'd4)
            temp = sub_out;
        else
            temp = w_prev;
        w_new = w_back ^ temp;
    end

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (.in_byte(sub_in[8*b +: 8]), .out_byte(sub_out[8*b +: 8]));
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rc_d    = rc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        kv_d    = kv_q;
        nr_d    = nr_q;
        load_en = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (aes_mode_legal(mode, MAX_KEY_BITS)) begin
                        key_d   = key;
                        mode_d  = mode;
                        busy_d  = 1'b1;
                        kv_d    = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                load_en = 1'b1;
                idx_d   = nk;
                cnt_d   = 6'd0;
                rc_d    = 4'd1;
                state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                wr_en = 1'b1;
                idx_d = idx_q + 6'd1;
                if (cnt_q == nk - 6'd1) begin
                    cnt_d = 6'd0;
                    rc_d  = rc_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
                if (idx_q == nwords - 6'd1) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                    nr_d    = aes_nr(mode_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_base = 6'({rd_round, 2'b00});

    always_comb begin
        rd_key_d = '0;
        if (kv_q && int'(rd_round) <= int'(nr_q))
            rd_key_d = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            mode_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rc_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            kv_q     <= 1'b0;
            nr_q     <= '0;
            rd_key_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rc_q     <= rc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            kv_q     <= kv_d;
            nr_q     <= nr_d;
            rd_key_q <= rd_key_d;
        end
    end

    // Word storage is deliberately not reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int j = 0; j < 8; j++)
                if (j < int'(nk)) w_q[j] <= key_q[255 - 32*j -: 32];
        end
        if (wr_en) w_q[idx_q] <= w_new;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign keys_valid = kv_q;
    assign num_rounds = nr_q;
    assign rd_key     = rd_key_q;

endmodule
